mod_sequencer: RTL and testbench
================================

// Module: mod_sequencer
// PURPOSE
//  Run-time controller for the modulator datapath (symbol counter -> PRBS -> FIR).
//  - Generates the symbol-rate strobe.
//  - Sequences FIR warm-up: zero-input flush before PRBS data is released.
//  - Drains the FIR tail on stop, then returns to idle.
//  - Sits between board controls (start/stop) and the PRBS/FIR enable/valid inputs.
// PARAMETERS
//  NB_COUNT   3   width of oversampling phase counter; one symbol = 2**NB_COUNT clocks
//  N_TAPS     24  FIR length; number of zero symbols in flush (>=2)
//  NB_TAPCNT  5   width of flush/drain symbol counter; must hold N_TAPS-1
// PORTS
//  clock          in   1         system clock
//  i_reset        in   1         synchronous reset, active-low
//  i_start        in   1         level; sampled only in IDLE
//  i_stop         in   1         level; stop/abort request
//  o_valid        out  1         symbol strobe to PRBS/FIR, 1 clk per symbol
//  o_prbs_enable  out  1         PRBS advance enable
//  o_fir_enable   out  1         FIR shift enable
//  o_fir_zero     out  1         force FIR input sample to 0 (flush/drain)
//  o_out_valid    out  1         FIR output sample is meaningful this strobe
//  o_busy         out  1         state != IDLE
//  o_done         out  1         1-clk pulse after drain completes
//  o_state        out  2         current state encoding (debug/LEDs)
// BEHAVIOUR
//  - Reset (i_reset==0 at posedge): state=IDLE, phase=0, tapcnt=0, stop_pend=0.
//    All outputs 0 during and after reset until the next transition.
//  - States: IDLE=0, FLUSH=1, RUN=2, DRAIN=3.
//  - Phase counter:
//    - Cleared in IDLE; +1 every clock otherwise, wraps 2**NB_COUNT-1 -> 0.
//    - o_valid = (state!=IDLE) && (phase=={NB_COUNT{1'b1}}).
//  - IDLE:
//    - i_start && !i_stop -> FLUSH next clock; phase=0, tapcnt=0.
//    - Simultaneous start+stop stays IDLE (stop wins).
//  - FLUSH:
//    - fir_enable=1, fir_zero=1, prbs_enable=0, out_valid=0.
//    - tapcnt +1 per o_valid.
//    - o_valid && tapcnt==N_TAPS-1 -> RUN, tapcnt=0.
//    - i_stop -> IDLE next clock (abort); o_done is NOT pulsed.
//  - RUN:
//    - prbs_enable=1, fir_enable=1, fir_zero=0, o_out_valid=o_valid.
//    - i_stop sets stop_pend (sticky).
//    - At o_valid with stop_pend (or i_stop same cycle) -> DRAIN; tapcnt=0, stop_pend=0.
//    - The symbol carried by that strobe is still a RUN symbol (out_valid=1).
//  - DRAIN:
//    - prbs_enable=0, fir_enable=1, fir_zero=1, o_out_valid=o_valid.
//    - tapcnt +1 per o_valid.
//    - o_valid && tapcnt==N_TAPS-2 -> IDLE, o_done=1 for the following clock.
//    - i_stop/i_start ignored.
//  - i_start outside IDLE is ignored. i_start held high after DONE restarts the flush.
//  - Latency: start sampled at edge k -> FLUSH from k+1. First o_valid at k+2**NB_COUNT.
//  - Mid-operation reset: immediate return to IDLE, no o_done.
//  - Enable outputs are decodes of the registered state (glitch-free, no extra delay).
//  - o_done is registered.
// STRUCTURE
//  - Shared package mod_pkg: state localparams (ST_IDLE..ST_DRAIN), state width,
//    default NB_COUNT / N_TAPS.
//  - Sub-module sym_timer: phase counter + o_valid decode
//    (params NB_COUNT; ports clock, i_reset, i_run, o_valid, o_phase).
//  - FSM, tap counter and stop_pend stay in mod_sequencer.
// TESTING  (NB_COUNT=3, N_TAPS=4; cycle 0 = edge sampling i_start)
//  1 Reset held 3 clk with i_start=1 -> all outputs 0, o_state=0.
//  2 Start pulse -> FLUSH cycles 1..32, o_valid at 8,16,24,32 with fir_zero=1;
//    RUN from 33, first o_out_valid at 40.
//  3 In RUN, i_stop 1 clk at 43 -> RUN continues to strobe at 48 (out_valid=1);
//    DRAIN 49..72, 3 strobes at 56,64,72; IDLE at 73; o_done=1 at 73 only.
//  4 i_stop at cycle 10 (FLUSH) -> IDLE at 11, o_busy=0, no o_done, never prbs_enable.
//  5 i_start=i_stop=1 in IDLE -> stays IDLE. i_start during RUN -> no effect.
//  6 i_reset=0 during DRAIN -> IDLE next clock, phase=0, o_done=0;
//    later start repeats scenario 2 timing.

Source files
------------

// File: rtl/mod_pkg.sv
// rtl/mod_pkg.sv - shared state encoding and default sizing for the modulator sequencer
//
// Purpose: state encoding, state width and default parameter values shared by
//          mod_sequencer and its sub-modules.
// Ports:   none (package).

package mod_pkg;

  localparam int ST_W          = 2;
  localparam int NB_COUNT_DEF  = 3;
  localparam int N_TAPS_DEF    = 24;
  localparam int NB_TAPCNT_DEF = 5;

  // The encoding is visible on o_state (debug LEDs), so values are fixed.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic logic st_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/mod_sequencer_sym_timer.sv
// rtl/mod_sequencer_sym_timer.sv - oversampling phase counter and symbol strobe
//
// Purpose: counts clocks within a symbol (2**NB_COUNT clocks per symbol) and
//          emits a one-clock strobe on the last phase of every symbol.
// Ports:
//   clock    in   system clock
//   i_reset  in   synchronous reset, active-low
//   i_run    in   counter runs while high, held at 0 while low
//   o_valid  out  symbol strobe (i_run && phase is all ones)
//   o_phase  out  current phase

module sym_timer #(
  parameter int NB_COUNT = 3
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_run,
  output logic                o_valid,
  output logic [NB_COUNT-1:0] o_phase
);

  logic [NB_COUNT-1:0] phase;

  // Phase is cleared whenever the sequencer is idle so the first strobe of a
  // new run always lands exactly 2**NB_COUNT clocks after the start.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      phase <= '0;
    end else if (!i_run) begin
      phase <= '0;
    end else begin
      phase <= phase + NB_COUNT'(1);
    end
  end

  // The strobe is gated by i_run: after an abort the phase may still be
  // non-zero for one idle clock and must not produce a strobe.
  assign o_valid = i_run && (phase == {NB_COUNT{1'b1}});
  assign o_phase = phase;

endmodule

// File: rtl/mod_sequencer.sv
// rtl/mod_sequencer.sv - run-time controller for the PRBS -> FIR modulator datapath
//
// Purpose: generates the symbol strobe, flushes the FIR with zero symbols
//          before releasing PRBS data, drains the FIR tail on stop and
//          returns to idle with a one-clock done pulse.
// Ports:
//   clock          in   system clock
//   i_reset        in   synchronous reset, active-low
//   i_start        in   start level, only looked at in IDLE
//   i_stop         in   stop/abort level
//   o_valid        out  symbol strobe, 1 clock per symbol
//   o_prbs_enable  out  PRBS advance enable
//   o_fir_enable   out  FIR shift enable
//   o_fir_zero     out  force FIR input to zero (flush/drain)
//   o_out_valid    out  FIR output meaningful on this strobe
//   o_busy         out  state != IDLE
//   o_done         out  registered pulse after drain completes
//   o_state        out  current state encoding

module mod_sequencer
  import mod_pkg::*;
#(
  parameter int NB_COUNT  = NB_COUNT_DEF,
  parameter int N_TAPS    = N_TAPS_DEF,
  parameter int NB_TAPCNT = NB_TAPCNT_DEF
) (
  input  logic            clock,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_stop,
  output logic            o_valid,
  output logic            o_prbs_enable,
  output logic            o_fir_enable,
  output logic            o_fir_zero,
  output logic            o_out_valid,
  output logic            o_busy,
  output logic            o_done,
  output logic [ST_W-1:0] o_state
);

  // Flush pushes N_TAPS zero symbols. Drain needs one fewer strobe because
  // the strobe that leaves RUN is itself still a RUN symbol.
  localparam logic [NB_TAPCNT-1:0] TAP_FLUSH_LAST = NB_TAPCNT'(N_TAPS - 1);
  localparam logic [NB_TAPCNT-1:0] TAP_DRAIN_LAST = NB_TAPCNT'(N_TAPS - 2);

  state_t               state_q, state_d;
  logic [NB_TAPCNT-1:0] tap_q, tap_d;
  logic                 pend_q, pend_d;
  logic                 done_q, done_d;

  logic                 sym_valid;
  logic [NB_COUNT-1:0]  phase;

  logic                 prbs_en, fir_en, fir_zero, out_valid;

  sym_timer #(
    .NB_COUNT (NB_COUNT)
  ) u_sym_timer (
    .clock   (clock),
    .i_reset (i_reset),
    .i_run   (st_busy(state_q)),
    .o_valid (sym_valid),
    .o_phase (phase)
  );

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    prbs_en   = 1'b0;
    fir_en    = 1'b0;
    fir_zero  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Stop wins over a simultaneous start.
        if (i_start && !i_stop) begin
          state_d = ST_FLUSH;
          tap_d   = '0;
        end
      end

      ST_FLUSH: begin
        fir_en   = 1'b1;
        fir_zero = 1'b1;
        // Abort: nothing meaningful has left the FIR yet, so no done pulse.
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (sym_valid) begin
          if (tap_q == TAP_FLUSH_LAST) begin
            state_d = ST_RUN;
            tap_d   = '0;
          end else begin
            tap_d = tap_q + NB_TAPCNT'(1);
          end
        end
      end

      ST_RUN: begin
        prbs_en   = 1'b1;
        fir_en    = 1'b1;
        out_valid = sym_valid;
        // A stop request is held until the symbol boundary so the symbol in
        // flight completes as a normal data symbol.
        pend_d    = pend_q | i_stop;
        if (sym_valid && (pend_q || i_stop)) begin
          state_d = ST_DRAIN;
          tap_d   = '0;
          pend_d  = 1'b0;
        end
      end

      ST_DRAIN: begin
        fir_en    = 1'b1;
        fir_zero  = 1'b1;
        out_valid = sym_valid;
        if (sym_valid) begin
          if (tap_q == TAP_DRAIN_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            tap_d = tap_q + NB_TAPCNT'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Every idle clock clears the phase, so the following clock starts at 0.
  a_idle_clears_phase : assert property (
    @(posedge clock) disable iff (!i_reset)
    (state_q == ST_IDLE) |=> (phase == '0)
  );

  assign o_valid       = sym_valid;
  assign o_prbs_enable = prbs_en;
  assign o_fir_enable  = fir_en;
  assign o_fir_zero    = fir_zero;
  assign o_out_valid   = out_valid;
  assign o_busy        = st_busy(state_q);
  assign o_done        = done_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_mod_sequencer.sv
// tb/tb_mod_sequencer.sv - scoreboard bench for mod_sequencer

module tb_mod_sequencer;

  logic       clock;
  logic       i_reset;
  logic       i_start;
  logic       i_stop;
  logic       o_valid;
  logic       o_prbs_enable;
  logic       o_fir_enable;
  logic       o_fir_zero;
  logic       o_out_valid;
  logic       o_busy;
  logic       o_done;
  logic [1:0] o_state;

  mod_sequencer #(
    .NB_COUNT  (3),
    .N_TAPS    (4),
    .NB_TAPCNT (5)
  ) dut (
    .clock         (clock),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .o_valid       (o_valid),
    .o_prbs_enable (o_prbs_enable),
    .o_fir_enable  (o_fir_enable),
    .o_fir_zero    (o_fir_zero),
    .o_out_valid   (o_out_valid),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_state       (o_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Vector order: valid, done, out_valid, prbs_enable, fir_enable, fir_zero, state[1:0]
  localparam logic [7:0] EV_FLUSH = 8'b1000_1101;
  localparam logic [7:0] EV_RUN   = 8'b1011_1010;
  localparam logic [7:0] EV_DRAIN = 8'b1010_1111;
  localparam logic [7:0] EV_DONE  = 8'b0100_0000;

  typedef struct {
    logic [7:0] vec;
    int         edge_at;
  } ev_t;

  ev_t sb[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  edge_n = 0;
  int  base   = 0;

  always @(posedge clock) edge_n <= edge_n + 1;

  function automatic logic [7:0] out_vec();
    return {o_valid, o_done, o_out_valid, o_prbs_enable, o_fir_enable, o_fir_zero, o_state};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Cycle c is observed at the negedge following edge base+c-1; inputs driven
  // there are sampled at edge base+c.
  task automatic expect_ev(input int c, input logic [7:0] v);
    ev_t e;
    e.vec     = v;
    e.edge_at = base + c - 1;
    sb.push_back(e);
  endtask

  task automatic goto_cycle(input int c);
    while (edge_n < base + c - 1) @(negedge clock);
  endtask

  // Monitor: whenever the DUT presents a strobe or a done pulse, the oldest
  // expected event must match in content and timing.
  always @(negedge clock) begin
    if (o_valid === 1'b1 || o_done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got vec %b at edge %0d, expected no output", out_vec(), edge_n);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("event_vec", 32'(out_vec()), 32'(e.vec));
        check("event_time", 32'(edge_n), 32'(e.edge_at));
      end
    end
  end

  // Start pulse, stop at 43, optional start held during RUN, drain to done.
  task automatic run_full(input bit start_in_run);
    @(negedge clock);
    base = edge_n + 1;
    expect_ev(8,  EV_FLUSH);
    expect_ev(16, EV_FLUSH);
    expect_ev(24, EV_FLUSH);
    expect_ev(32, EV_FLUSH);
    expect_ev(40, EV_RUN);
    expect_ev(48, EV_RUN);
    expect_ev(56, EV_DRAIN);
    expect_ev(64, EV_DRAIN);
    expect_ev(72, EV_DRAIN);
    expect_ev(73, EV_DONE);
    i_start = 1'b1;
    @(negedge clock);
    i_start = 1'b0;
    check("flush_state_c1", 32'(o_state), 32'd1);
    check("flush_busy_c1", 32'(o_busy), 32'd1);
    goto_cycle(33);
    check("run_state_c33", 32'(o_state), 32'd2);
    if (start_in_run) begin
      goto_cycle(35);
      i_start = 1'b1;
    end
    goto_cycle(43);
    i_stop = 1'b1;
    goto_cycle(44);
    i_stop = 1'b0;
    goto_cycle(46);
    i_start = 1'b0;
    goto_cycle(48);
    check("run_state_c48", 32'(o_state), 32'd2);
    goto_cycle(49);
    check("drain_state_c49", 32'(o_state), 32'd3);
    goto_cycle(73);
    check("idle_state_c73", 32'(o_state), 32'd0);
    check("idle_busy_c73", 32'(o_busy), 32'd0);
    goto_cycle(74);
    check("done_gone_c74", 32'(o_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prbs_seen;
    i_reset = 1'b0;
    i_start = 1'b1;
    i_stop  = 1'b0;

    // 1: reset held with start asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("reset_outputs", 32'(out_vec()), 32'd0);
      check("reset_busy", 32'(o_busy), 32'd0);
    end
    i_reset = 1'b1;
    i_start = 1'b0;

    // 5a: start and stop together in IDLE
    @(negedge clock);
    i_start = 1'b1;
    i_stop  = 1'b1;
    repeat (3) @(negedge clock);
    check("start_stop_state", 32'(o_state), 32'd0);
    check("start_stop_busy", 32'(o_busy), 32'd0);
    i_start = 1'b0;
    i_stop  = 1'b0;

    // 2, 3, 5b: full run with start held during RUN
    run_full(1'b1);

    // 4: abort during FLUSH
    @(negedge clock);
    base = edge_n + 1;
    expect_ev(8, EV_FLUSH);
    i_start = 1'b1;
    @(negedge clock);
    i_start = 1'b0;
    prbs_seen = 0;
    for (int c = 1; c <= 10; c++) begin
      goto_cycle(c);
      if (o_prbs_enable !== 1'b0) prbs_seen++;
    end
    i_stop = 1'b1;
    goto_cycle(11);
    i_stop = 1'b0;
    check("abort_state_c11", 32'(o_state), 32'd0);
    check("abort_busy_c11", 32'(o_busy), 32'd0);
    check("abort_no_prbs", 32'(prbs_seen), 32'd0);
    goto_cycle(20);
    check("abort_still_idle", 32'(out_vec()), 32'd0);

    // 6: reset in the middle of DRAIN, then a clean restart
    @(negedge clock);
    base = edge_n + 1;
    expect_ev(8,  EV_FLUSH);
    expect_ev(16, EV_FLUSH);
    expect_ev(24, EV_FLUSH);
    expect_ev(32, EV_FLUSH);
    expect_ev(40, EV_RUN);
    expect_ev(48, EV_RUN);
    expect_ev(56, EV_DRAIN);
    i_start = 1'b1;
    @(negedge clock);
    i_start = 1'b0;
    goto_cycle(43);
    i_stop = 1'b1;
    goto_cycle(44);
    i_stop = 1'b0;
    goto_cycle(60);
    check("pre_reset_drain", 32'(o_state), 32'd3);
    i_reset = 1'b0;
    goto_cycle(61);
    i_reset = 1'b1;
    check("midreset_outputs", 32'(out_vec()), 32'd0);
    check("midreset_busy", 32'(o_busy), 32'd0);
    run_full(1'b0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clock);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
